// File: rtl/addsub_nibble_seq_if.sv
// ============================================================================
// Module      : addsub_nibble_seq_if
// Description : Start/busy/done handshake and operand/result bus for the
//               nibble-serial add/sub controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface addsub_nibble_seq_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic          start;
   logic          sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          cout;
   logic          overflow;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, cout, overflow
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, cout, overflow
   );
endinterface

`default_nettype wire

// File: rtl/addsub_nibble_seq.sv
// ============================================================================
// Module      : addsub_nibble_seq
// Description : W-bit add/subtract computed LSB-first, one nibble per clock,
//               through a single 4-bit slice. Optional ADDSUB_SAT_EN macro
//               enables signed saturation of overflowed results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   addsub_nibble_seq_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            sub_q, sub_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    result_q, result_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [3:0]      nib_a;
   logic [3:0]      nib_b;
   logic [4:0]      sum5;
   logic            slice_ovf;
   logic            last_nib;

   // Current slice: B is inverted for subtract, the carry register supplies the +1.
   assign nib_a     = a_q[{cnt_q, 2'b00} +: 4];
   assign nib_b     = b_q[{cnt_q, 2'b00} +: 4] ^ {4{sub_q}};
   assign sum5      = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
   // Carry into bit 3 recovered as a3^b3^s3, then XORed with the carry out.
   assign slice_ovf = (nib_a[3] ^ nib_b[3] ^ sum5[3]) ^ sum5[4];
   assign last_nib  = (cnt_q == CW'(NIBBLES - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      sub_d    = sub_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               sub_d   = bus.sub;
               carry_d = bus.sub;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            result_d[{cnt_q, 2'b00} +: 4] = sum5[3:0];
            carry_d = sum5[4];
            cnt_d   = cnt_q + CW'(1);
            if (last_nib) begin
               cout_d  = sum5[4];
               ovf_d   = slice_ovf;
               state_d = S_DONE;
`ifdef ADDSUB_SAT_EN
               if (slice_ovf) begin
                  result_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                                      : {1'b0, {(W-1){1'b1}}};
               end
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         sub_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         sub_q    <= sub_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy     = (state_q == S_RUN);
   assign bus.done     = (state_q == S_DONE);
   assign bus.result   = result_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;

endmodule

`default_nettype wire

// File: doc/addsub_nibble_seq.md
Name: addsub_nibble_seq

Overview:
- Multi-cycle controller that sits directly upstream of the 4-bit add/sub slice.
- Performs a W-bit add or subtract by streaming operand nibbles LSB-first through one 4-bit add/sub datapath, one nibble per clock.
- Registers the carry between nibbles and assembles the full-width result with carry-out and signed-overflow flags.
- Consumer sees a start/busy/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; W = 4*NIBBLES (default 16-bit); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = a+b, 1 = a-b; latched on accept
- a  input  W  operand A; latched on accept
- b  input  W  operand B; latched on accept
- busy  output  1  high while nibbles are being processed
- done  output  1  single-cycle pulse when result, cout and overflow are valid
- result  output  W  assembled sum/difference
- cout  output  1  final carry; on subtract, 1 = no borrow
- overflow  output  1  two's-complement overflow of the W-bit operation

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE; busy=0, done=0, result=0, cout=0, overflow=0
  - nibble counter=0, carry register=0
  - Reset during RUN aborts the operation; no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch a, b, sub; carry register set to sub; counter cleared; next state RUN.
  - result keeps its previous value.
- RUN, on each edge:
  - Nibble i of a is added to (nibble i of b XOR {4{sub}}) plus the carry register.
  - The 4-bit sum is written to result[4i+3:4i]; the carry out goes to the carry register; the counter increments.
  - When i = NIBBLES-1:
    - cout = carry out
    - overflow = carry into bit 3 of that slice XOR carry out of it
    - next state DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, next state RUN); otherwise next state IDLE.
- Latency:
  - start accepted at edge k.
  - busy=1 during cycles k+1 .. k+NIBBLES.
  - done=1 in cycle k+NIBBLES+1.
  - Throughput: one operation per NIBBLES+1 cycles.
- start asserted while in RUN is ignored; it is not queued, and a, b, sub changes are ignored.
- result, cout and overflow are stable from the done cycle until the first RUN edge of the next operation.
  - Upper result nibbles change progressively during RUN; the consumer samples only on done.
- Arithmetic is modulo 2^W; no sign extension; cout and overflow are not sticky across operations.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined:
  - In the DONE transition, if overflow=1, result is replaced by the signed saturation value: 2^(W-1)-1 if the true result was positive (a sign bit 0), else 2^(W-1) (most negative).
  - overflow still reports 1; cout is unchanged.
  - Latency is unchanged.
- Undefined: result is the raw wrapped value.

Test Plan:
- Add:
  - Stimulus: a=0x1234, b=0x1111, sub=0, start at edge k.
  - Required: busy high cycles k+1..k+4; done at k+5 with result=0x2345, cout=0, overflow=0.
- Carry chain through all nibbles:
  - Stimulus: a=0xFFFF, b=0x0001, sub=0.
  - Required: result=0x0000, cout=1, overflow=0.
- Subtract with borrow:
  - Stimulus: a=0x0002, b=0x000E, sub=1.
  - Required: result=0xFFF4, cout=0, overflow=0.
  - Stimulus: a=0x000E, b=0x0002.
  - Required: result=0x000C, cout=1.
- Signed overflow:
  - Stimulus: a=0x7FFF+0x0001.
  - Required: overflow=1; result=0x8000 (0x7FFF with ADDSUB_SAT_EN).
  - Stimulus: a=0x8000-0x0001.
  - Required: overflow=1; result=0x7FFF (0x8000 with ADDSUB_SAT_EN).
- Handshake:
  - Stimulus: start pulsed at k+2 during RUN with different operands.
  - Required: ignored; first result correct.
  - Stimulus: start held high in DONE.
  - Required: next operation begins and its done arrives 5 cycles later.
- Reset mid-operation:
  - Stimulus: rst_n driven low between edges at k+2.
  - Required: all outputs 0 immediately without a clock edge; no done pulse; a new start after release completes normally.
